swd_xfer_ctrl: RTL

Transfer sequencer sitting between the command layer and the SWD bit engine (`swdIF`). It accepts one DP/AP transfer request at a time over a valid/ready interface and holds the request fields stable for the bit engine. It pulses the engine's `go` handshake, retries automatically on WAIT up to a configured limit, and latches FAULT as a sticky condition. Each completed transfer returns exactly one response record (ack, read data, parity error, retry count).

---
 rtl/swd_xfer_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/swd_xfer_ctrl.sv
// swd_xfer_ctrl: sequences a single DP/AP transfer through the SWD bit engine.
// It holds the request fields for the engine and reissues on WAIT up to a
// limit latched at acceptance. A FAULT ack is remembered in fault_sticky;
// while that flag is set, new requests are answered with FAULT without
// touching the bus. Each transfer returns exactly one response record.
module swd_xfer_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_addr32,
    input  logic        req_rnw,
    input  logic        req_apndp,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_data,
    output logic        rsp_perr,
    output logic [7:0]  rsp_retries,
    input  logic [7:0]  wait_retries,
    input  logic        clr_fault,
    output logic        fault_sticky,
    output logic [1:0]  swd_addr32,
    output logic        swd_rnw,
    output logic        swd_apndp,
    output logic [31:0] swd_dwrite,
    output logic        swd_go,
    input  logic        swd_idle,
    input  logic [2:0]  swd_ack,
    input  logic [31:0] swd_dread,
    input  logic        swd_perr
);

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, EVAL, RESP} state_t;

    state_t     state;
    logic [7:0] retry_lim;
    logic [7:0] retry_cnt;

    // Transfer FSM. All outputs are registered. req_ready comes up on the
    // first clock after reset is released and drops at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_ack      <= 3'b000;
            rsp_data     <= 32'h0;
            rsp_perr     <= 1'b0;
            rsp_retries  <= 8'h0;
            fault_sticky <= 1'b0;
            swd_addr32   <= 2'b00;
            swd_rnw      <= 1'b0;
            swd_apndp    <= 1'b0;
            swd_dwrite   <= 32'h0;
            swd_go       <= 1'b0;
            retry_lim    <= 8'h0;
            retry_cnt    <= 8'h0;
        end else begin
            // A clear pulse is applied first so that a FAULT detected in EVAL
            // during the same cycle overrides it.
            if (clr_fault)
                fault_sticky <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        swd_addr32 <= req_addr32;
                        swd_rnw    <= req_rnw;
                        swd_apndp  <= req_apndp;
                        swd_dwrite <= req_wdata;
                        retry_lim  <= wait_retries;
                        retry_cnt  <= 8'h0;
                        if (fault_sticky) begin
                            // Still faulted: answer immediately without using the bus.
                            rsp_ack     <= ACK_FAULT;
                            rsp_data    <= 32'h0;
                            rsp_perr    <= 1'b0;
                            rsp_retries <= 8'h0;
                            rsp_valid   <= 1'b1;
                            state       <= RESP;
                        end else begin
                            swd_go <= 1'b1;
                            state  <= ISSUE;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Hold go until the engine leaves idle.
                    if (!swd_idle) begin
                        swd_go <= 1'b0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (swd_idle)
                        state <= EVAL;
                end
                EVAL: begin
                    if (swd_ack == ACK_WAIT && retry_cnt < retry_lim) begin
                        retry_cnt <= retry_cnt + 8'd1;
                        swd_go    <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        rsp_ack     <= swd_ack;
                        rsp_data    <= (swd_ack == ACK_OK && swd_rnw) ? swd_dread : 32'h0;
                        rsp_perr    <= (swd_ack == ACK_OK) & swd_perr & swd_rnw;
                        rsp_retries <= retry_cnt;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                    if (swd_ack == ACK_FAULT)
                        fault_sticky <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
